// File: rtl/factory_test_pkg.sv
// factory_test_pkg: mode encodings, seeds and default polynomials for the factory-test tile
package factory_test_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_MISR  = 2'd3
    } mode_e;

    localparam logic [7:0] SEED_COUNT     = 8'h00;
    localparam logic [7:0] SEED_WALK      = 8'h01;
    localparam logic [7:0] SEED_MISR      = 8'h00;
    localparam logic [7:0] DEF_LFSR_SEED  = 8'h01;
    localparam logic [7:0] DEF_LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] DEF_MISR_POLY  = 8'h1D;

    // Value loaded into the generator when a mode is entered
    function automatic logic [7:0] seed(input mode_e m, input logic [7:0] lfsr_seed);
        return (m == MODE_LFSR) ? lfsr_seed :
               (m == MODE_WALK) ? SEED_WALK :
               (m == MODE_MISR) ? SEED_MISR : SEED_COUNT;
    endfunction

endpackage

// File: rtl/ft_sync.sv
// ft_sync: N-stage flop synchroniser with asynchronous active-low clear
module ft_sync #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] stage_q;
    logic [STAGES-1:0][W-1:0] stage_d;

    // Shift the input one stage deeper each clock
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d};
    end

    // Stage register, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tt_um_factory_test_multi.sv
// tt_um_factory_test_multi: loopback plus counter/LFSR/walk/MISR generator tile with prescaler and freeze
module tt_um_factory_test_multi
    import factory_test_pkg::*;
#(
    parameter int         RST_SYNC_STAGES = 2,
    parameter int         SYNC_STAGES     = 2,
    parameter int         PRESCALE_W      = 15,
    parameter logic [7:0] LFSR_TAPS       = DEF_LFSR_TAPS,
    parameter logic [7:0] LFSR_SEED       = DEF_LFSR_SEED,
    parameter logic [7:0] MISR_POLY       = DEF_MISR_POLY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic                  rst_ok;
    logic                  rst_i;
    logic [6:0]            ctl_s;
    logic [7:0]            uio_s;
    mode_e                 mode_s;
    logic [3:0]            div_s;
    logic                  frz_s;
    logic                  test_en;
    logic                  drive;
    logic                  tick;
    int                    div_c;
    logic [PRESCALE_W-1:0] mask;
    logic [7:0]            gen_next;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [7:0]            gen_q, gen_d;
    mode_e                 mode_q, mode_d;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, ena};

    ft_sync #(.STAGES(RST_SYNC_STAGES), .W(1)) u_rst_sync (
        .clk(clk), .rst_n(rst_n), .d(1'b1), .q(rst_ok)
    );

    ft_sync #(.STAGES(SYNC_STAGES), .W(7)) u_ctl_sync (
        .clk(clk), .rst_n(rst_n), .d(ui_in[7:1]), .q(ctl_s)
    );

    ft_sync #(.STAGES(SYNC_STAGES), .W(8)) u_uio_sync (
        .clk(clk), .rst_n(rst_n), .d(uio_in), .q(uio_s)
    );

    assign rst_i   = !rst_ok;
    assign mode_s  = mode_e'(ctl_s[1:0]);
    assign div_s   = ctl_s[5:2];
    assign frz_s   = ctl_s[6];
    assign test_en = ui_in[0];
    assign drive   = test_en && (mode_q != MODE_MISR);

    // Generator step for the active mode
    always_comb begin
        case (mode_q)
            MODE_COUNT: gen_next = gen_q + 8'd1;
            MODE_LFSR:  gen_next = (gen_q >> 1) ^ (gen_q[0] ? LFSR_TAPS : 8'h00);
            MODE_WALK:  gen_next = {gen_q[6:0], gen_q[7]};
            default:    gen_next = {gen_q[6:0], 1'b0} ^ (gen_q[7] ? MISR_POLY : 8'h00) ^ uio_s;
        endcase
    end

    // Prescaler tick, mode reseed priority, freeze and synchronous reset hold
    always_comb begin
        presc_d = presc_q;
        gen_d   = gen_q;
        mode_d  = mode_q;
        div_c   = (int'(div_s) > PRESCALE_W) ? PRESCALE_W : int'(div_s);
        mask    = (PRESCALE_W'(1) << div_c) - PRESCALE_W'(1);
        tick    = !frz_s && ((presc_q & mask) == mask);
        if (rst_i) begin
            presc_d = '0;
            gen_d   = 8'h00;
            mode_d  = MODE_COUNT;
        end else if (mode_s != mode_q) begin
            presc_d = '0;
            gen_d   = seed(mode_s, LFSR_SEED);
            mode_d  = mode_s;
        end else begin
            presc_d = frz_s ? presc_q : presc_q + PRESCALE_W'(1);
            gen_d   = tick ? gen_next : gen_q;
        end
    end

    // State registers, cleared at once by rst_n without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            gen_q   <= 8'h00;
            mode_q  <= MODE_COUNT;
        end else begin
            presc_q <= presc_d;
            gen_q   <= gen_d;
            mode_q  <= mode_d;
        end
    end

    assign uo_out  = test_en ? gen_q : (ui_in ^ uio_in);
    assign uio_out = drive ? gen_q : 8'h00;
    assign uio_oe  = drive ? 8'hFF : 8'h00;

endmodule
